// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-load arbiter: state encoding,
// requester count and the round-robin winner search.
package reg_arb_pkg;

  localparam int unsigned NREQ = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Round-robin search starting one past the last served requester,
  // wrapping 2 -> 0. Returns 'last' when nothing is requesting.
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req,
                                         input logic [1:0]      last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    idx     = last;
    found   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/reg_load_arbiter_load_reg.sv
// Shared W-bit register: loads d when load is high, otherwise holds.
module load_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register with enable; cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_load_arbiter.sv
// Three-requester round-robin arbiter writing one shared register.
//   state | meaning
//   IDLE  | waiting; samples req, picks winner, captures its data
//   LOAD  | holding register driven into the shared register
//   ACK   | shared register updated; one-cycle gnt to the winner
module reg_load_arbiter
  import reg_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    d0,
  input  logic [W-1:0]    d1,
  input  logic [W-1:0]    d2,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic [1:0]      owner,
  output logic [W-1:0]    q
);

  state_t       state;
  logic [W-1:0] hold;
  logic [1:0]   win;
  logic [W-1:0] win_data;
  logic         load_en;

  assign win     = rr_pick(req, owner);
  assign load_en = (state == LOAD);

  // Data of the requester that would win at this IDLE sampling edge.
  always_comb begin
    win_data = d0;
    case (win)
      2'd1:    win_data = d1;
      2'd2:    win_data = d2;
      default: win_data = d0;
    endcase
  end

  // Sequencing FSM with registered gnt/busy, pointer and holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      hold  <= '0;
      owner <= 2'd2;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= win;
            hold  <= win_data;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          gnt   <= NREQ'(3'b001 << owner);
          state <= ACK;
        end
        ACK: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  load_reg #(.W(W)) u_load_reg (
    .clk  (clk),
    .rst  (rst),
    .load (load_en),
    .d    (hold),
    .q    (q)
  );

endmodule

// File: doc/reg_load_arbiter.md
REG_LOAD_ARBITER -- requirements
Module: reg_load_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port: req  input  3  per-requester write request, bit i = requester i.
REQ-004 SHALL have port: d0, d1, d2  input  4 each  write data of requester 0/1/2.
REQ-005 SHALL have port: gnt  output  3  one-hot completion pulse to the served requester.
REQ-006 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-007 SHALL have port: owner  output  2  index of last served requester.
REQ-008 SHALL have port: q  output  4  current content of the shared 4-bit register.
REQ-009 SHALL have parameter: W, default 4, shared register and data width.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, ACK; ACK->IDLE unconditionally, LOAD->ACK unconditionally.
REQ-011 SHALL, in IDLE with req != 0 at a rising edge, select a winner, latch its data into a W-bit holding register, and enter LOAD.
REQ-012 SHALL stay in IDLE while req == 0; holding register and q unchanged.
REQ-013 SHALL select the winner round-robin: search order starts at (owner+1) mod 3 and wraps 2->0.
REQ-014 SHALL update owner to the winner index on the IDLE->LOAD edge.
REQ-015 SHALL assert the internal register load only during LOAD, driving the holding register onto the register data input.
REQ-016 SHALL update q on the LOAD->ACK edge; q is otherwise held.
REQ-017 SHALL assert gnt[owner] for exactly the one ACK cycle; gnt = 0 in all other states.
REQ-018 SHALL give a write latency of 2 edges from request sampling to q update and 3 edges to IDLE; back-to-back service rate is one write per 3 cycles.
REQ-019 SHALL ignore req and d* changes in LOAD and ACK; data is captured only at the IDLE sampling edge.
REQ-020 SHALL treat a req still high in the IDLE cycle after its gnt as a new request, arbitrated normally.
REQ-021 SHALL, for simultaneous requests, serve all pending requesters in rotation, none starved for more than 2 other services.
REQ-022 SHALL never treat owner == 3; owner is always 0..2.

Reset
REQ-023 SHALL, while rst = 0, immediately force state IDLE, q = 0, holding register = 0, owner = 2, gnt = 0, busy = 0.
REQ-024 SHALL abandon any in-flight write on reset assertion mid-LOAD or mid-ACK; no gnt is issued for it.
REQ-025 SHALL, after reset release with owner = 2, give requester 0 first priority.

Structure
REQ-026 SHALL place state encodings (IDLE=2'd0, LOAD=2'd1, ACK=2'd2) and requester count 3 in a shared package reg_arb_pkg.
REQ-027 SHALL instantiate the shared register as one sub-module load_reg: W-bit register with async active-low rst, load enable, data in, q out, holding when load = 0.
REQ-028 SHALL keep FSM, round-robin pointer and holding register in reg_load_arbiter.

Verification
REQ-029 SHALL check: rst low while req=3'b111 -> q=0, gnt=0, busy=0, owner=2 throughout; release -> normal operation.
REQ-030 SHALL check: single req[1] with d1=4'b1010 held until gnt -> q=4'b1010 two edges after sampling, gnt=3'b010 for one cycle, owner=1.
REQ-031 SHALL check: req=3'b111, d0=4'h3, d1=4'hA, d2=4'hF held (each dropped after its gnt) -> gnt order 001,010,100; q sequence 3,A,F; each gnt 3 cycles apart.
REQ-032 SHALL check: requester 0 held continuously with req[2] also pending after owner=0 -> requester 2 served next, then 0; no back-to-back service of 0.
REQ-033 SHALL check: d2 changed from 4'h5 to 4'hC during LOAD -> q=4'h5.
REQ-034 SHALL check: rst pulsed low during LOAD for requester 1 with d1=4'h7 -> q=0, no gnt, IDLE after release, next service goes to requester 0 if requesting.
